zero_threshold_detector: RTL

- Parametrised, registered successor to the team's 3-input "at least two inputs false" combinational detector.
- Counts the low bits of an N-bit input each cycle and compares the count against a threshold K.
- The output asserts only after the condition has held for HOLD consecutive cycles, and releases only after it has been absent for HOLD consecutive cycles (time hysteresis).
- Produces edge pulses and a saturating event counter to drive board LED/status logic.

---
 rtl/zero_threshold_detector.sv | 131 +++++++++++++
 1 files changed

// File: rtl/zero_threshold_detector.sv
// Registered N-input zero-count detector with threshold K, HOLD-cycle time hysteresis,
// edge pulses and a saturating event counter. Define ZERO_DET_STICKY_EN to add clr/sticky.
module zero_threshold_detector #(
  parameter int N    = 3,
  parameter int K    = 2,
  parameter int HOLD = 4,
  parameter int EVW  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [N-1:0]               din,
`ifdef ZERO_DET_STICKY_EN
  input  logic                       clr,
  output logic                       sticky,
`endif
  output logic [$clog2(N+1)-1:0]     zero_cnt,
  output logic                       q,
  output logic                       q_rise,
  output logic                       q_fall,
  output logic [EVW-1:0]             evt_cnt
);

  localparam int ZW  = $clog2(N+1);
  localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;

  generate
    if (K < 1 || K > N || HOLD < 1) begin : g_bad_params
      $error("zero_threshold_detector: need 1 <= K <= N and HOLD >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ARM, ACTIVE, REL} state_t;

  state_t          state, state_n;
  logic [HCW-1:0]  hc, hc_n;
  logic [ZW-1:0]   zeros_n;
  logic            hit;
  logic            q_n;

  always_comb begin
    zeros_n = '0;
    for (int unsigned i = 0; i < N; i++)
      zeros_n = zeros_n + ZW'(!din[i]);
  end

  assign hit = (zero_cnt >= ZW'(K));

  // hc counts consecutive qualifying (ARM) or non-qualifying (REL) enabled edges
  always_comb begin
    state_n = state;
    hc_n    = hc;
    if (en) begin
      unique case (state)
        IDLE: if (hit) begin
          if (HOLD == 1) state_n = ACTIVE;
          else begin
            state_n = ARM;
            hc_n    = HCW'(1);
          end
        end
        ARM: begin
          if (!hit) begin
            state_n = IDLE;
            hc_n    = '0;
          end else if (hc == HCW'(HOLD-1)) begin
            state_n = ACTIVE;
            hc_n    = '0;
          end else begin
            hc_n = hc + HCW'(1);
          end
        end
        ACTIVE: if (!hit) begin
          if (HOLD == 1) state_n = IDLE;
          else begin
            state_n = REL;
            hc_n    = HCW'(1);
          end
        end
        REL: begin
          if (hit) begin
            state_n = ACTIVE;
            hc_n    = '0;
          end else if (hc == HCW'(HOLD-1)) begin
            state_n = IDLE;
            hc_n    = '0;
          end else begin
            hc_n = hc + HCW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          hc_n    = '0;
        end
      endcase
    end
  end

  assign q_n = (state_n == ACTIVE) || (state_n == REL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      hc       <= '0;
      zero_cnt <= '0;
      q        <= 1'b0;
      q_rise   <= 1'b0;
      q_fall   <= 1'b0;
      evt_cnt  <= '0;
`ifdef ZERO_DET_STICKY_EN
      sticky   <= 1'b0;
`endif
    end else begin
      zero_cnt <= zeros_n;
      state    <= state_n;
      hc       <= hc_n;
      q        <= q_n;
      q_rise   <= q_n && !q;
      q_fall   <= !q_n && q;
      if (q_n && !q && evt_cnt != '1)
        evt_cnt <= evt_cnt + EVW'(1);
`ifdef ZERO_DET_STICKY_EN
      if (q_n && !q)
        sticky <= 1'b1;
      else if (clr)
        sticky <= 1'b0;
`endif
    end
  end

endmodule
